// File: rtl/mips_memory_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_memory_access_stage                                                   |
// | MEM stage: req/ack data-memory access with store lane steering and load    |
// | extraction/extension. Optional macro: MIPS_MEMORY_ACCESS_ALIGN_CHECK_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mips_memory_access_stage #(
  parameter int TAG_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_writeEnable,
  input  logic [1:0]           in_byteEnable,
  input  logic                 in_byteExtend,
  input  logic [31:0]          in_address,
  input  logic [31:0]          in_storeData,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic [31:0]          mem_addr,
  output logic [3:0]           mem_wmask,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_busError,
  output logic                 out_fault
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [9:0]           count_q, count_d;
  logic [1:0]           size_q, size_d;
  logic                 ext_q, ext_d;
  logic [1:0]           lane_q, lane_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [31:0]          data_q, data_d;
  logic                 err_q, err_d;
  logic                 fault_q, fault_d;
  logic                 write_q, write_d;
  logic [31:0]          addr_q, addr_d;
  logic [3:0]           wmask_q, wmask_d;
  logic [31:0]          wdata_q, wdata_d;

  logic                 accept;
  logic                 misaligned;
  logic [3:0]           store_mask;
  logic [31:0]          store_data;
  logic [7:0]           load_byte;
  logic [15:0]          load_half;
  logic [31:0]          load_data;

`ifdef MIPS_MEMORY_ACCESS_ALIGN_CHECK_EN
  assign misaligned = ((in_byteEnable == 2'd2) && in_address[0]) ||
                      ((in_byteEnable == 2'd3) && (in_address[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Stores replicate the source across lanes; the mask selects the lanes written.
  always_comb begin
    store_mask = 4'b0000;
    store_data = in_storeData;
    case (in_byteEnable)
      2'd1: begin
        store_mask = 4'b0001 << in_address[1:0];
        store_data = {4{in_storeData[7:0]}};
      end
      2'd2: begin
        store_mask = in_address[1] ? 4'b1100 : 4'b0011;
        store_data = {2{in_storeData[15:0]}};
      end
      2'd3: store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
    if (!in_writeEnable) store_mask = 4'b0000;
  end

  always_comb begin
    case (lane_q)
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd1:    load_data = {{24{~ext_q & load_byte[7]}}, load_byte};
      2'd2:    load_data = {{16{~ext_q & load_half[15]}}, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    size_d  = size_q;
    ext_d   = ext_q;
    lane_d  = lane_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    fault_d = fault_q;
    write_d = write_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_ACCESS: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d = ST_DONE;
          data_d  = write_q ? 32'd0 : load_data;
          write_d = 1'b0;
          wmask_d = 4'b0000;
        end else if (count_q == TIMEOUT_LAST) begin
          state_d = ST_DONE;
          data_d  = 32'd0;
          err_d   = 1'b1;
          write_d = 1'b0;
          wmask_d = 4'b0000;
        end else begin
          count_d = count_q + 10'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = state_q;
    endcase

    if (accept) begin
      tag_d   = in_tag;
      err_d   = 1'b0;
      fault_d = 1'b0;
      count_d = 10'd0;
      if (in_byteEnable == 2'd0) begin
        state_d = ST_DONE;
        data_d  = in_address;
      end else if (misaligned) begin
        state_d = ST_DONE;
        data_d  = 32'd0;
        fault_d = 1'b1;
      end else begin
        state_d = ST_ACCESS;
        write_d = in_writeEnable;
        addr_d  = {in_address[31:2], 2'b00};
        wmask_d = store_mask;
        wdata_d = store_data;
        size_d  = in_byteEnable;
        ext_d   = in_byteExtend;
        lane_d  = in_address[1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= 10'd0;
      size_q  <= 2'd0;
      ext_q   <= 1'b0;
      lane_q  <= 2'd0;
      tag_q   <= '0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wmask_q <= 4'b0000;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      size_q  <= size_d;
      ext_q   <= ext_d;
      lane_q  <= lane_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      fault_q <= fault_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req      = (state_q == ST_ACCESS);
  assign mem_write    = write_q;
  assign mem_addr     = addr_q;
  assign mem_wmask    = wmask_q;
  assign mem_wdata    = wdata_q;
  assign out_valid    = (state_q == ST_DONE);
  assign out_data     = data_q;
  assign out_tag      = tag_q;
  assign out_busError = err_q;
  assign out_fault    = fault_q;

endmodule
`default_nettype wire

// File: doc/mips_memory_access_stage.md
Name: mips_memory_access_stage

Overview:
- MEM-stage datapath unit that consumes the memory control bundle (writeEnable, byteEnable, byteExtend) generated in decode and carried down the pipeline.
- Performs the data-memory access over a req/ack bus with variable latency, including byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
- Applies valid/ready backpressure upstream and drives a registered result toward writeback.

Parameters:
- TAG_WIDTH, 8, width of the opaque tag (dest register, etc.) carried alongside each op.
- TIMEOUT_CYCLES, 255, number of cycles in ACCESS without mem_ack before the access is abandoned; range 1..1023.

Ports:
- clock  input  1  stage clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream op present.
- in_ready  output  1  stage accepts an op this cycle.
- in_writeEnable  input  1  1 = store.
- in_byteEnable  input  2  access size: 0 None, 1 Byte, 2 Half, 3 Word.
- in_byteExtend  input  1  load extension: 0 Signed, 1 Unsigned.
- in_address  input  32  ALU result / effective address.
- in_storeData  input  32  rt value.
- in_tag  input  TAG_WIDTH  passthrough.
- mem_req  output  1  bus request; held until mem_ack.
- mem_write  output  1  store request.
- mem_addr  output  32  {address[31:2],2'b00}.
- mem_wmask  output  4  byte lane write mask.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  bus completion (1 cycle).
- mem_rdata  input  32  read word, valid with mem_ack.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_data  output  32  result value.
- out_tag  output  TAG_WIDTH  passthrough.
- out_busError  output  1  access timed out.
- out_fault  output  1  misaligned access (optional feature).

Behaviour:
- Reset (async, reset_n=0): state IDLE; mem_req, mem_write, out_valid, out_busError, out_fault = 0; mem_wmask = 0; out_data, out_tag, mem_addr, mem_wdata = 0. This holds mid-access: an outstanding req drops immediately, and an ack arriving after reset release is ignored in IDLE.
- States: IDLE, ACCESS, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). An accept occurs when in_valid & in_ready.
- Accept with byteEnable=None:
  - Go to DONE next cycle, out_data = in_address, no bus activity.
  - 1-cycle latency.
- Accept with byteEnable≠None:
  - Register the op, go to ACCESS.
  - mem_req=1 from the next cycle, along with mem_write, mem_addr, mem_wmask, mem_wdata. All are held stable until ack.
- Store lanes (little-endian):
  - Byte: mask = 1<<addr[1:0], wdata = {4{sd[7:0]}}.
  - Half: mask = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
  - Word: mask = 1111, wdata = sd.
  - Loads drive mask 0000.
- ACCESS with mem_ack=1:
  - Drop mem_req on the next edge and go to DONE.
  - Load: out_data = selected lane, extended per byteExtend. Byte lane = addr[1:0], half lane = addr[1].
  - Store: out_data = 0.
  - Minimum memory-op latency = accept edge + 1 req cycle + 1 = result visible 2 cycles after accept with zero-wait ack.
- Timeout counter:
  - Cleared on entry to ACCESS, increments each ACCESS cycle without ack.
  - When it equals TIMEOUT_CYCLES-1 and no ack: drop req, go to DONE with out_busError=1, out_data=0.
  - An ack on that same cycle wins; no error.
- DONE:
  - out_valid=1; out_data, out_tag, out_busError, out_fault held until out_ready.
  - out_ready with a simultaneous accept chains back-to-back: DONE→DONE for a None op, DONE→ACCESS for a memory op.
  - out_ready with no accept → IDLE, out_valid=0.
- mem_ack outside ACCESS is ignored.

Optional Feature:
- Macro: MIPS_MEMORY_ACCESS_ALIGN_CHECK_EN.
- Defined:
  - Misaligned accesses (Half with addr[0]=1, Word with addr[1:0]≠0) never raise mem_req.
  - They go straight to DONE with out_fault=1, out_data=0, at 1-cycle latency.
- Undefined:
  - out_fault is tied 0.
  - Half ignores addr[0]; Word ignores addr[1:0].

Test Plan:
- None op, address 0x12345678, out_ready=1 → out_valid next cycle, out_data 0x12345678, mem_req never asserts.
- Lb at addr 0x103, rdata 0x80FF_0000, ack after 3 wait cycles → mem_addr 0x100, mem_req high 4 cycles, out_data 0xFFFF_FF80. Same with Lbu → 0x0000_0080.
- Sh at addr 0x202, storeData 0xAAAA_BEEF → mem_wmask 1100, mem_wdata 0xBEEF_BEEF, mem_write=1; out_data 0 after ack.
- No ack with TIMEOUT_CYCLES=4 → mem_req high exactly 4 cycles, then out_busError=1 and out_data=0.
- Two back-to-back Lw with out_ready low for 2 cycles on the first result → in_ready low during hold, first result stable, second bus request starts the cycle after out_ready rises.
- Reset_n pulsed low during ACCESS → mem_req drops asynchronously; after release state is IDLE and a late ack produces no out_valid. With the feature defined, Lw at 0x101 → out_fault=1 with no mem_req.
